// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory word port
// of the load/store unit, bundled for the MEM stage.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid,
        output req_write,
        output req_size,
        output req_unsigned,
        output req_address,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_error,
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_size,
        input  req_unsigned,
        input  req_address,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_error,
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time onto a big-endian
// word memory, sub-word stores done as read-modify-write.
module load_store_unit #(
    parameter int unsigned DM_SIZE = 1024
) (
    input logic         clock,
    input logic         reset_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, READ, WRITE, RMW_READ, RMW_WRITE, RESP
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [31:0] MAX_BASE = 32'(DM_SIZE - 4);

    state_e      state_q;
    logic        ready_q;
    logic        rvalid_q;
    logic        rerr_q;
    logic [31:0] rdata_q;
    logic        mrd_q;
    logic        mwr_q;
    logic [31:0] maddr_q;
    logic [31:0] mwdata_q;
    logic [15:0] wdata_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        uns_q;

    logic [31:0] base_d;
    logic        err_d;
    logic [7:0]  lb_d;
    logic [15:0] lh_d;
    logic [31:0] load_d;
    logic [31:0] merge_d;

    always_comb begin
        base_d = {bus.req_address[31:2], 2'b00};
        case (bus.req_size)
            SZ_B:    err_d = 1'b0;
            SZ_H:    err_d = bus.req_address[0];
            SZ_W:    err_d = |bus.req_address[1:0];
            default: err_d = 1'b1;
        endcase
        if (base_d > MAX_BASE) err_d = 1'b1;
    end

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        merge_d = bus.mem_rdata;
        lb_d    = bus.mem_rdata[31:24];
        case (off_q)
            2'd0: lb_d = bus.mem_rdata[31:24];
            2'd1: lb_d = bus.mem_rdata[23:16];
            2'd2: lb_d = bus.mem_rdata[15:8];
            default: lb_d = bus.mem_rdata[7:0];
        endcase
        lh_d = off_q[1] ? bus.mem_rdata[15:0]
                        : bus.mem_rdata[31:16];
        if (size_q == SZ_B) begin
            case (off_q)
                2'd0: merge_d[31:24] = wdata_q[7:0];
                2'd1: merge_d[23:16] = wdata_q[7:0];
                2'd2: merge_d[15:8]  = wdata_q[7:0];
                default: merge_d[7:0] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merge_d[15:0] = wdata_q;
        end else begin
            merge_d[31:16] = wdata_q;
        end
        case (size_q)
            SZ_B: load_d = {{24{~uns_q & lb_d[7]}}, lb_d};
            SZ_H: load_d = {{16{~uns_q & lh_d[15]}}, lh_d};
            default: load_d = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            wdata_q  <= '0;
            size_q   <= SZ_B;
            off_q    <= 2'd0;
            uns_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.req_valid) begin
                    ready_q <= 1'b0;
                    size_q  <= bus.req_size;
                    off_q   <= bus.req_address[1:0];
                    uns_q   <= bus.req_unsigned;
                    wdata_q <= bus.req_wdata[15:0];
                    maddr_q <= base_d;
                    if (err_d) begin
                        state_q  <= RESP;
                        rvalid_q <= 1'b1;
                        rerr_q   <= 1'b1;
                        rdata_q  <= '0;
                    end else if (!bus.req_write) begin
                        state_q <= READ;
                        mrd_q   <= 1'b1;
                    end else if (bus.req_size == SZ_W) begin
                        state_q  <= WRITE;
                        mwr_q    <= 1'b1;
                        mwdata_q <= bus.req_wdata;
                    end else begin
                        state_q <= RMW_READ;
                        mrd_q   <= 1'b1;
                    end
                end
                READ: begin
                    state_q  <= RESP;
                    mrd_q    <= 1'b0;
                    rvalid_q <= 1'b1;
                    rerr_q   <= 1'b0;
                    rdata_q  <= load_d;
                end
                RMW_READ: begin
                    state_q  <= RMW_WRITE;
                    mrd_q    <= 1'b0;
                    mwr_q    <= 1'b1;
                    mwdata_q <= merge_d;
                end
                WRITE, RMW_WRITE: begin
                    state_q  <= RESP;
                    mwr_q    <= 1'b0;
                    mwdata_q <= '0;
                    rvalid_q <= 1'b1;
                    rerr_q   <= 1'b0;
                    rdata_q  <= '0;
                end
                RESP: begin
                    state_q  <= IDLE;
                    rvalid_q <= 1'b0;
                    ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.resp_valid  = rvalid_q;
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_error  = rerr_q;
    assign bus.mem_read    = mrd_q;
    assign bus.mem_write   = mwr_q;
    assign bus.mem_address = maddr_q;
    assign bus.mem_wdata   = mwdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, byte-array
// reference model with random traffic, busy and reset cases.
module tb_load_store_unit;
    localparam int DM = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.DM_SIZE(DM)) dut (
        .clock  (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    logic [7:0] mem [DM];
    logic [7:0] rm  [DM];
    int checks = 0;
    int errors = 0;

    // Word memory view of the byte array, big-endian.
    always_comb begin
        bus.mem_rdata = 32'h0;
        if (bus.mem_address <= 32'(DM - 4))
            bus.mem_rdata = {mem[bus.mem_address[9:0]],
                             mem[bus.mem_address[9:0] + 10'd1],
                             mem[bus.mem_address[9:0] + 10'd2],
                             mem[bus.mem_address[9:0] + 10'd3]};
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DM; i++) mem[i] <= rm[i];
        end else if (bus.mem_write && bus.mem_address <= 32'(DM - 4)) begin
            mem[bus.mem_address[9:0]]         <= bus.mem_wdata[31:24];
            mem[bus.mem_address[9:0] + 10'd1] <= bus.mem_wdata[23:16];
            mem[bus.mem_address[9:0] + 10'd2] <= bus.mem_wdata[15:8];
            mem[bus.mem_address[9:0] + 10'd3] <= bus.mem_wdata[7:0];
        end
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: access size in bytes, big-endian byte order.
    function automatic void model(
        input logic w, input logic [1:0] sz, input logic u,
        input logic [31:0] a, input logic [31:0] wd,
        output logic [31:0] rd, output logic e,
        output int lat, output int nrd, output int nwr);
        int nb;
        logic [63:0] v;
        e = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
            (sz == 2'd2 && a[1:0] != 2'd0) ||
            ((a & ~32'd3) > 32'(DM - 4));
        rd = 0; lat = 1; nrd = 0; nwr = 0;
        if (e) return;
        nb = 1 << sz;
        if (!w) begin
            v = 0;
            for (int i = 0; i < nb; i++)
                v = (v << 8) | 64'(rm[int'(a) + i]);
            if (!u && nb < 4 && v[8*nb-1])
                v = v | (~64'h0 << (8*nb));
            rd = v[31:0]; lat = 2; nrd = 1;
        end else begin
            for (int i = 0; i < nb; i++)
                rm[int'(a) + i] = 8'(wd >> (8*(nb-1-i)));
            lat = (nb == 4) ? 2 : 3;
            nrd = (nb == 4) ? 0 : 1;
            nwr = 1;
        end
    endfunction

    task automatic do_req(
        input logic w, input logic [1:0] sz, input logic u,
        input logic [31:0] a, input logic [31:0] wd,
        output logic [31:0] rd, output logic e,
        output int lat, output int nrd, output int nwr,
        output bit bad);
        int n;
        @(negedge clk);
        bus.req_write = w; bus.req_size = sz;
        bus.req_unsigned = u; bus.req_address = a;
        bus.req_wdata = wd; bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk); n++;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 99; nrd = 0; nwr = 0; bad = 0; rd = 0; e = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.mem_read) nrd++;
            if (bus.mem_write) nwr++;
            if (bus.mem_read && bus.mem_write) bad = 1;
            if (!bus.mem_write && bus.mem_wdata != 0) bad = 1;
            if ((bus.mem_read || bus.mem_write) &&
                bus.mem_address != {a[31:2], 2'b00}) bad = 1;
            if (bus.resp_valid) begin
                lat = c; rd = bus.resp_rdata; e = bus.resp_error;
                if (bus.req_ready) bad = 1;
                break;
            end
        end
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_e;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];

    task automatic run_one(input string tag, input vec_t v);
        logic [31:0] rd, mrd;
        logic e, me;
        int lat, nrd, nwr, mlat, mnrd, mnwr;
        bit bad;
        do_req(v.w, v.sz, v.u, v.a, v.wd, rd, e, lat, nrd, nwr, bad);
        model(v.w, v.sz, v.u, v.a, v.wd, mrd, me, mlat, mnrd, mnwr);
        check({tag, " rdata"}, 64'(rd), 64'(v.exp_rd));
        check({tag, " error"}, 64'(e), 64'(v.exp_e));
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, " memcycles"}, {31'd0, bad, 16'(nrd), 16'(nwr)},
              {32'd0, 16'(mnrd), 16'(mnwr)});
    endtask

    initial begin
        vec_t v;
        logic [31:0] rd, got[4];
        logic e;
        int lat, nrd, nwr, nresp, phase;
        bit bad;

        bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0;
        bus.req_unsigned = 0; bus.req_address = 0; bus.req_wdata = 0;
        for (int i = 0; i < DM; i++) rm[i] = 8'($urandom);
        rm[16] = 8'h80; rm[17] = 8'hFF; rm[18] = 8'h7F; rm[19] = 8'h01;

        repeat (3) @(negedge clk);
        check("reset outputs",
              {bus.req_ready, bus.resp_valid, bus.resp_error,
               bus.mem_read, bus.mem_write},
              {1'b1, 4'b0});
        check("reset data",
              {bus.resp_rdata, bus.mem_address | bus.mem_wdata}, 64'h0);
        preload = 1'b0;
        rst_n = 1'b1;

        tbl.push_back('{1, 2'd2, 0, 32'h8,   32'h11223344, 32'h0, 0, 2});
        tbl.push_back('{0, 2'd2, 0, 32'h8,   32'h0, 32'h11223344, 0, 2});
        tbl.push_back('{0, 2'd0, 0, 32'h10,  32'h0, 32'hFFFFFF80, 0, 2});
        tbl.push_back('{0, 2'd0, 1, 32'h10,  32'h0, 32'h00000080, 0, 2});
        tbl.push_back('{0, 2'd0, 0, 32'h12,  32'h0, 32'h0000007F, 0, 2});
        tbl.push_back('{0, 2'd1, 0, 32'h10,  32'h0, 32'hFFFF80FF, 0, 2});
        tbl.push_back('{0, 2'd1, 1, 32'h12,  32'h0, 32'h00007F01, 0, 2});
        tbl.push_back('{1, 2'd0, 0, 32'h11,  32'hAB, 32'h0, 0, 3});
        tbl.push_back('{0, 2'd2, 0, 32'h10,  32'h0, 32'h80AB7F01, 0, 2});
        tbl.push_back('{1, 2'd1, 0, 32'h12,  32'hBEEF, 32'h0, 0, 3});
        tbl.push_back('{0, 2'd2, 0, 32'h10,  32'h0, 32'h80ABBEEF, 0, 2});
        tbl.push_back('{0, 2'd1, 0, 32'h5,   32'h0, 32'h0, 1, 1});
        tbl.push_back('{1, 2'd2, 0, 32'h6,   32'h1234, 32'h0, 1, 1});
        tbl.push_back('{0, 2'd2, 0, 32'h3FE, 32'h0, 32'h0, 1, 1});
        tbl.push_back('{0, 2'd3, 0, 32'h20,  32'h0, 32'h0, 1, 1});
        tbl.push_back('{1, 2'd2, 0, 32'h3FC, 32'hDEADBEEF, 32'h0, 0, 2});
        tbl.push_back('{0, 2'd2, 0, 32'h3FC, 32'h0, 32'hDEADBEEF, 0, 2});
        tbl.push_back('{0, 2'd0, 1, 32'h3FF, 32'h0, 32'h000000EF, 0, 2});
        tbl.push_back('{0, 2'd2, 0, 32'h400, 32'h0, 32'h0, 1, 1});
        tbl.push_back('{1, 2'd0, 0, 32'h401, 32'h55, 32'h0, 1, 1});
        foreach (tbl[i]) run_one($sformatf("vec%0d", i), tbl[i]);

        // Second request held high while a store is in flight.
        @(negedge clk);
        bus.req_write = 1; bus.req_size = 2'd2; bus.req_unsigned = 0;
        bus.req_address = 32'h40; bus.req_wdata = 32'hCAFEF00D;
        bus.req_valid = 1;
        v = '{1, 2'd2, 0, 32'h40, 32'hCAFEF00D, 0, 0, 0};
        model(v.w, v.sz, v.u, v.a, v.wd, rd, e, lat, nrd, nwr);
        phase = 0; nresp = 0;
        for (int n = 0; n < 16; n++) begin
            if (bus.resp_valid) begin
                if (nresp < 4) got[nresp] = bus.resp_rdata;
                nresp++;
            end
            if (bus.req_valid && bus.req_ready) begin
                @(posedge clk);
                #1;
                if (phase == 0) begin
                    bus.req_write = 0; bus.req_address = 32'h40;
                end else begin
                    bus.req_valid = 0;
                end
                phase++;
            end
            @(negedge clk);
        end
        bus.req_valid = 0;
        check("busy responses", 64'(nresp), 64'd2);
        check("busy first rdata", 64'(got[0]), 64'h0);
        check("busy second rdata", 64'(got[1]), 64'hCAFEF00D);

        // Reset during the read half of a byte store.
        @(negedge clk);
        bus.req_write = 1; bus.req_size = 2'd0;
        bus.req_address = 32'h21; bus.req_wdata = 32'h5A;
        bus.req_valid = 1;
        @(posedge clk);
        #1 bus.req_valid = 0;
        @(negedge clk);
        check("rst pre mem_read", 64'(bus.mem_read), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst async outputs",
              {bus.req_ready, bus.resp_valid, bus.resp_error,
               bus.mem_read, bus.mem_write},
              {1'b1, 4'b0});
        check("rst async data", {bus.mem_address, bus.mem_wdata}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst word intact",
              64'({mem[32], mem[33], mem[34], mem[35]}),
              64'({rm[32], rm[33], rm[34], rm[35]}));
        run_one("post reset",
                '{0, 2'd2, 0, 32'h20, 0,
                  {rm[32], rm[33], rm[34], rm[35]}, 0, 2});

        // Random traffic against the byte-array model.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] mrd;
            logic me;
            int mlat, mnrd, mnwr;
            logic w, u;
            logic [1:0] sz;
            logic [31:0] a, wd;
            w = 1'($urandom);
            u = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3
                                             : 2'($urandom_range(0, 2));
            a = $urandom_range(0, 1060);
            wd = $urandom;
            do_req(w, sz, u, a, wd, rd, e, lat, nrd, nwr, bad);
            model(w, sz, u, a, wd, mrd, me, mlat, mnrd, mnwr);
            check($sformatf("rnd%0d", i),
                  {rd, 7'(lat), e, 8'(nrd), 7'(nwr), bad},
                  {mrd, 7'(mlat), me, 8'(mnrd), 7'(mnwr), 1'b0});
        end

        @(negedge clk);
        nresp = 0;
        for (int i = 0; i < DM; i++) if (mem[i] !== rm[i]) nresp++;
        check("final memory image", 64'(nresp), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
